// File: rtl/imm_decode_stage.sv
// Immediate decode stage: RV immediate extraction into a 2-entry output FIFO.
// Optional accepted-instruction counter enabled by defining IMM_DECODE_CNT_EN.
module imm_decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_type,
   output logic            out_illegal
`ifdef IMM_DECODE_CNT_EN
  ,output logic [15:0]     acc_cnt
`endif
);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("imm_decode_stage: XLEN must be 32 or 64");
      end
   endgenerate

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      ty;
      logic            ill;
   } ent_t;

   localparam logic [2:0] T_I = 3'd0;
   localparam logic [2:0] T_S = 3'd1;
   localparam logic [2:0] T_B = 3'd2;
   localparam logic [2:0] T_J = 3'd3;
   localparam logic [2:0] T_U = 3'd4;
   localparam logic [2:0] T_R = 3'd5;
   localparam logic [2:0] T_X = 3'd7;

   logic [6:0]         opc;
   logic               is_i;
   logic               is_s;
   logic               is_b;
   logic               is_j;
   logic               is_u;
   logic               is_r;
   logic               is_sh;
   logic signed [31:0] imm32;
   ent_t               dec;

   assign opc   = in_instr[6:0];
   assign is_i  = (opc == 7'b0010011) || (opc == 7'b0000011) ||
                  (opc == 7'b1100111) || (opc == 7'b1110011);
   assign is_s  = (opc == 7'b0100011);
   assign is_b  = (opc == 7'b1100011);
   assign is_j  = (opc == 7'b1101111);
   assign is_u  = (opc == 7'b0110111) || (opc == 7'b0010111);
   assign is_r  = (opc == 7'b0110011);
   // funct3 001/101 on OP-IMM carries a shift amount, not a signed imm
   assign is_sh = (opc == 7'b0010011) && (in_instr[13:12] == 2'b01);

   always_comb begin
      imm32   = '0;
      dec.ty  = T_X;
      dec.ill = 1'b0;
      unique case (1'b1)
         is_i: begin
            dec.ty = T_I;
            if (is_sh) begin
               if (XLEN == 64) imm32 = {26'b0, in_instr[25:20]};
               else            imm32 = {27'b0, in_instr[24:20]};
            end else begin
               imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
         end
         is_s: begin
            dec.ty = T_S;
            imm32  = {{20{in_instr[31]}}, in_instr[31:25],
                      in_instr[11:7]};
         end
         is_b: begin
            dec.ty = T_B;
            imm32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
         end
         is_j: begin
            dec.ty = T_J;
            imm32  = {{11{in_instr[31]}}, in_instr[31],
                      in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
         end
         is_u: begin
            dec.ty = T_U;
            imm32  = {in_instr[31:12], 12'b0};
         end
         is_r: begin
            dec.ty = T_R;
         end
         default: begin
            dec.ty  = T_X;
            dec.ill = 1'b1;
         end
      endcase
      dec.imm = XLEN'(imm32);
   end

   ent_t       mem [2];
   logic [1:0] occ;
   logic       wr_ptr;
   logic       rd_ptr;
   logic       rdy_en;
   logic       push;
   logic       pop;

   // rdy_en holds off acceptance until the first edge after reset release
   assign in_ready  = rdy_en && !occ[1] && !flush;
   assign out_valid = (occ != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         occ    <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else if (flush) begin
         occ    <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         unique case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= dec;
      end
   end

   ent_t head;

   always_comb begin
      head = mem[rd_ptr];
      if (!out_valid) head = '0;
   end

   assign out_imm     = head.imm;
   assign out_type    = head.ty;
   assign out_illegal = head.ill;

`ifdef IMM_DECODE_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_cnt <= 16'd0;
      end else if (push && acc_cnt != 16'hFFFF) begin
         acc_cnt <= acc_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64, any other value is an elaboration error.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw RV instruction word.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_type  out  3  format code.
- out_illegal  out  1  opcode not recognised.
- acc_cnt  out  16  accepted-instruction count (present only per REQ-017).

Function
REQ-003 SHALL decode the format from in_instr[6:0] itself:
- 0010011, 0000011, 1100111, 1110011 -> I (type 0).
- 0100011 -> S (1).
- 1100011 -> B (2).
- 1101111 -> J (3).
- 0110111, 0010111 -> U (4).
- 0110011 -> R (5), imm 0.
- any other -> type 7, imm 0, out_illegal=1.
REQ-004 SHALL sign-extend I/S/B/J immediates from instr[31] to XLEN; B and J bit 0 forced 0.
REQ-005 SHALL form U as {instr[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-006 For opcode 0010011 with funct3 001 or 101, SHALL output zero-extended shamt: instr[24:20] if XLEN=32, instr[25:20] if XLEN=64; type stays 0.
REQ-007 SHALL buffer results in a 2-entry FIFO; a transfer occurs on in_valid&&in_ready (input) or out_valid&&out_ready (output).
REQ-008 in_ready SHALL be (occupancy<2) && !flush, with occupancy taken from registered state; no combinational path from out_ready to in_ready.
REQ-009 Latency SHALL be 1 cycle: an instruction accepted at edge N appears on out_* after edge N when the FIFO was empty.
REQ-010 SHALL preserve order; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-011 Simultaneous push and pop at occupancy 1 or 2 SHALL keep occupancy unchanged; at occupancy 2 no push occurs (in_ready=0).
REQ-012 flush=1 at an edge SHALL set occupancy to 0; no push that cycle; a pop in that cycle is ignored for counting; out_valid=0 on the next cycle.
REQ-013 When out_valid=0, out_imm, out_type and out_illegal SHALL be 0.

Reset
REQ-014 rstn low SHALL asynchronously clear occupancy, pointers, storage and acc_cnt; out_valid=0, in_ready=0 while rstn=0.
REQ-015 Deassertion SHALL take effect at the next clk edge; in_ready=1 the cycle after rstn rises.
REQ-016 Reset mid-transfer SHALL drop all buffered entries; none reappear after reset.

Configuration
REQ-017 Macro IMM_DECODE_CNT_EN:
- Defined: acc_cnt port exists; increments by 1 per input transfer, saturates at 16'hFFFF, cleared by reset, not cleared by flush.
- Undefined: port and counter are absent; all other behaviour is identical.

Verification
REQ-018 XLEN=32, push 0xFFF00093 -> out_imm=0xFFFFFFFF, type 0, illegal 0, one cycle after acceptance.
REQ-019 XLEN=32, push 0xFE112E23 (sw) -> out_imm=0xFFFFFFFC, type 1; push 0x0000007F -> type 7, imm 0, illegal 1.
REQ-020 XLEN=64:
- push 0x800002B7 -> out_imm=0xFFFFFFFF80000000, type 4.
- push 0x03F09093 (slli 63) -> out_imm=63, type 0.
REQ-021 out_ready=0, push three instructions back-to-back -> in_ready drops after the second; raising out_ready drains all three in order with stable outputs while stalled.
REQ-022 FIFO full, assert flush with in_valid=1 -> input not accepted, out_valid=0 next cycle; with IMM_DECODE_CNT_EN, acc_cnt unchanged by the flush.
